// File: rtl/jtframe_ioctl_prog.sv
// -----------------------------------------------------------------------------
// jtframe_ioctl_prog
//
// Purpose:
//   Turns the byte-wide ROM download stream coming from the MiST/NeptUNO SPI
//   loader into 16-bit SDRAM programming writes. Each accepted byte becomes one
//   masked word write: the byte is replicated on both lanes and the DQM-style
//   mask selects the lane that is actually written. The linear download space
//   (after an optional discarded header) is split across the four SDRAM banks.
//   One output register plus a one-entry skid buffer absorb the controller's
//   acknowledge latency. A byte arriving while both are full is dropped and
//   flagged on the sticky overflow output.
//
// Parameters:
//   SDRAMW     word-address width of prog_addr (at most 25)
//   HEADER     leading download bytes to discard; later addresses shift down
//   BA1_START  first byte offset (after header removal) mapped to bank 1
//   BA2_START  first byte offset mapped to bank 2
//   BA3_START  first byte offset mapped to bank 3
//   SWAB       1 = even bytes go to the high lane instead of the low lane
//
// Ports:
//   clk          system clock (same as clk_rom)
//   rst_n        synchronous reset, active low
//   downloading  ROM download in progress
//   ioctl_addr   byte address of the current download byte
//   ioctl_data   download byte
//   ioctl_wr     one-cycle strobe, byte valid
//   prog_addr    word address within the selected bank
//   prog_data    download byte replicated on both lanes
//   prog_mask    lane mask, 1 = lane NOT written
//   prog_ba      target bank
//   prog_we      write request, held until prog_rdy
//   prog_rdy     one-cycle write-done pulse from the SDRAM controller
//   dwnld_busy   download active or writes still pending
//   overflow     sticky: a byte was dropped because the buffer was full
// -----------------------------------------------------------------------------
module jtframe_ioctl_prog #(
  parameter int          SDRAMW    = 23,
  parameter int          HEADER    = 0,
  parameter logic [24:0] BA1_START = 25'h10_0000,
  parameter logic [24:0] BA2_START = 25'h20_0000,
  parameter logic [24:0] BA3_START = 25'h30_0000,
  parameter bit          SWAB      = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              downloading,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_data,
  input  logic              ioctl_wr,
  output logic [SDRAMW-1:0] prog_addr,
  output logic [15:0]       prog_data,
  output logic [1:0]        prog_mask,
  output logic [1:0]        prog_ba,
  output logic              prog_we,
  input  logic              prog_rdy,
  output logic              dwnld_busy,
  output logic              overflow
);

  // One complete SDRAM programming write, as held in OUT or in SKID.
  typedef struct packed {
    logic [SDRAMW-1:0] addr;
    logic [15:0]       data;
    logic [1:0]        mask;
    logic [1:0]        ba;
  } prog_word_t;

  localparam logic [24:0] HDR = 25'(HEADER);

  // ---------------------------------------------------------------------------
  // Header filter. With no header every address passes; the explicit branch
  // keeps the comparison from degenerating into an always-true compare.
  // ---------------------------------------------------------------------------
  logic w_hdr_ok;

  generate
    if (HEADER == 0) begin : g_no_header
      assign w_hdr_ok = 1'b1;
    end else begin : g_header
      assign w_hdr_ok = (ioctl_addr >= HDR);
    end
  endgenerate

  logic w_accept;
  assign w_accept = ioctl_wr && downloading && w_hdr_ok;

  // ---------------------------------------------------------------------------
  // Address map: header removal, bank split, byte-to-word conversion and lane
  // selection for the incoming byte.
  // ---------------------------------------------------------------------------
  logic [24:0] w_a;
  logic [24:0] w_off;
  logic [1:0]  w_ba;
  prog_word_t  w_new;

  // NOTE: every signal assigned in always_comb gets a value on every path
  // (defaults first); a path that leaves one unassigned infers a latch.
  always_comb begin
    w_a   = ioctl_addr - HDR;
    w_off = w_a;
    w_ba  = 2'd0;
    if (w_a < BA1_START) begin
      w_ba  = 2'd0;
      w_off = w_a;
    end else if (w_a < BA2_START) begin
      w_ba  = 2'd1;
      w_off = w_a - BA1_START;
    end else if (w_a < BA3_START) begin
      w_ba  = 2'd2;
      w_off = w_a - BA2_START;
    end else begin
      w_ba  = 2'd3;
      w_off = w_a - BA3_START;
    end

    w_new      = '0;
    // Word address is the byte offset halved, truncated to the SDRAM width.
    w_new.addr = SDRAMW'(w_off >> 1);
    w_new.data = {ioctl_data, ioctl_data};
    // Mask bit set = lane left untouched. Even bytes land in the low lane
    // unless the lanes are swapped.
    w_new.mask = (w_off[0] ^ SWAB) ? 2'b01 : 2'b10;
    w_new.ba   = w_ba;
  end

  // ---------------------------------------------------------------------------
  // OUT register, SKID buffer, busy and overflow flags.
  // ---------------------------------------------------------------------------
  prog_word_t r_out;
  logic       r_out_vld;
  prog_word_t r_skid;
  logic       r_skid_vld;
  logic       r_busy;
  logic       r_overflow;
  logic       r_dl_d;

  logic w_ack;
  assign w_ack = r_out_vld && prog_rdy;   // prog_rdy with nothing pending is ignored

  // NOTE: sequential state is updated only with non-blocking assignments, so
  // every right-hand side below sees the register values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // NOTE: the skid payload is reset as well even though its valid bit
      // alone would suffice; it is a single word and keeps the state fully
      // defined after reset.
      r_out      <= '0;
      r_out_vld  <= 1'b0;
      r_skid     <= '0;
      r_skid_vld <= 1'b0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
      r_dl_d     <= 1'b0;
    end else begin
      r_dl_d <= downloading;

      // A fresh download clears the sticky overflow flag. A drop at this same
      // edge is assigned further down and therefore wins.
      if (downloading && !r_dl_d) begin
        r_overflow <= 1'b0;
      end

      // Completion of the pending write: promote SKID or go idle.
      if (w_ack) begin
        if (r_skid_vld) begin
          r_out      <= r_skid;
          r_skid_vld <= 1'b0;
        end else begin
          r_out_vld <= 1'b0;
        end
      end

      // Placement of a newly accepted byte. The later assignments override the
      // drain above where both touch the same register.
      if (w_accept) begin
        if (!r_skid_vld && (!r_out_vld || w_ack)) begin
          // OUT idle or freeing now, nothing queued ahead: straight to OUT.
          r_out     <= w_new;
          r_out_vld <= 1'b1;
        end else if (!r_skid_vld || w_ack) begin
          // Either SKID is free, or SKID is moving into OUT at this edge.
          r_skid     <= w_new;
          r_skid_vld <= 1'b1;
        end else begin
          r_overflow <= 1'b1;
        end
      end

      // Busy follows downloading but only drops once every write has landed.
      if (downloading) begin
        r_busy <= 1'b1;
      end else if (!r_out_vld && !r_skid_vld) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign prog_addr  = r_out.addr;
  assign prog_data  = r_out.data;
  assign prog_mask  = r_out.mask;
  assign prog_ba    = r_out.ba;
  assign prog_we    = r_out_vld;
  assign dwnld_busy = r_busy;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_jtframe_ioctl_prog.sv
// -----------------------------------------------------------------------------
// tb_jtframe_ioctl_prog
//
// Self-checking bench for jtframe_ioctl_prog. Three instances share the same
// stimulus: default parameters, swapped lanes, and a 16-byte header. Inputs
// change just after the falling edge; outputs are sampled at the falling edge.
// -----------------------------------------------------------------------------
module tb_jtframe_ioctl_prog;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic        prog_rdy;

  // default instance
  logic [22:0] d0_addr;
  logic [15:0] d0_data;
  logic [1:0]  d0_mask, d0_ba;
  logic        d0_we, d0_busy, d0_ovf;
  // SWAB = 1 instance
  logic [22:0] d1_addr;
  logic [15:0] d1_data;
  logic [1:0]  d1_mask, d1_ba;
  logic        d1_we, d1_busy, d1_ovf;
  // HEADER = 16 instance
  logic [22:0] d2_addr;
  logic [15:0] d2_data;
  logic [1:0]  d2_mask, d2_ba;
  logic        d2_we, d2_busy, d2_ovf;

  always #5 clk = ~clk;

  jtframe_ioctl_prog dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(d0_addr), .prog_data(d0_data), .prog_mask(d0_mask),
    .prog_ba(d0_ba), .prog_we(d0_we), .prog_rdy(prog_rdy),
    .dwnld_busy(d0_busy), .overflow(d0_ovf)
  );

  jtframe_ioctl_prog #(.SWAB(1'b1)) dut_swab (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(d1_addr), .prog_data(d1_data), .prog_mask(d1_mask),
    .prog_ba(d1_ba), .prog_we(d1_we), .prog_rdy(prog_rdy),
    .dwnld_busy(d1_busy), .overflow(d1_ovf)
  );

  jtframe_ioctl_prog #(.HEADER(16)) dut_hdr (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
    .prog_addr(d2_addr), .prog_data(d2_data), .prog_mask(d2_mask),
    .prog_ba(d2_ba), .prog_we(d2_we), .prog_rdy(prog_rdy),
    .dwnld_busy(d2_busy), .overflow(d2_ovf)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic send(input logic [24:0] addr, input logic [7:0] data);
    ioctl_addr = addr;
    ioctl_data = data;
    ioctl_wr   = 1'b1;
    step();
    ioctl_wr   = 1'b0;
  endtask

  task automatic ack();
    prog_rdy = 1'b1;
    step();
    prog_rdy = 1'b0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    downloading = 1'b0;
    ioctl_wr    = 1'b0;
    prog_rdy    = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [22:0] exp_addr;
    logic [1:0]  exp_ba;
    logic [1:0]  exp_mask;
    logic [1:0]  exp_mask_swab;
  } vec_t;

  vec_t vecs[8];
  logic hdr_seen;

  initial begin
    vecs[0] = '{25'h000_0000, 8'hAA, 23'h00_0000, 2'd0, 2'b10, 2'b01};
    vecs[1] = '{25'h000_0001, 8'h55, 23'h00_0000, 2'd0, 2'b01, 2'b10};
    vecs[2] = '{25'h020_0005, 8'h3C, 23'h00_0002, 2'd2, 2'b01, 2'b10};
    vecs[3] = '{25'h00F_FFFF, 8'h11, 23'h07_FFFF, 2'd0, 2'b01, 2'b10};
    vecs[4] = '{25'h010_0000, 8'h22, 23'h00_0000, 2'd1, 2'b10, 2'b01};
    vecs[5] = '{25'h030_0002, 8'h44, 23'h00_0001, 2'd3, 2'b10, 2'b01};
    vecs[6] = '{25'h1FF_FFFF, 8'h99, 23'h67_FFFF, 2'd3, 2'b01, 2'b10};
    vecs[7] = '{25'h02F_FFFE, 8'h77, 23'h07_FFFF, 2'd2, 2'b10, 2'b01};

    ioctl_addr = '0;
    ioctl_data = '0;
    do_reset();

    // ---- reset state ----
    check("rst_we",   d0_we,   0);
    check("rst_addr", d0_addr, 0);
    check("rst_data", d0_data, 0);
    check("rst_mask", d0_mask, 0);
    check("rst_ba",   d0_ba,   0);
    check("rst_busy", d0_busy, 0);
    check("rst_ovf",  d0_ovf,  0);

    // ---- ioctl_wr without downloading is ignored ----
    send(25'h10, 8'h77);
    check("nodl_we", d0_we, 0);

    // ---- busy rises after downloading ----
    downloading = 1'b1;
    step();
    check("busy_up", d0_busy, 1);

    // ---- first write, prog_rdy 3 cycles later ----
    send(25'h0, 8'hAA);
    check("w0_we",   d0_we,   1);
    check("w0_addr", d0_addr, 0);
    check("w0_ba",   d0_ba,   0);
    check("w0_data", d0_data, 16'hAAAA);
    check("w0_mask", d0_mask, 2'b10);
    step();
    check("w0_we_c2", d0_we, 1);
    step();
    check("w0_we_c3",   d0_we,   1);
    check("w0_data_c3", d0_data, 16'hAAAA);
    ack();
    check("w0_we_drop", d0_we, 0);

    // ---- table-driven address map ----
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].addr, vecs[i].data);
      check($sformatf("v%0d_we", i),    d0_we,   1);
      check($sformatf("v%0d_addr", i),  d0_addr, vecs[i].exp_addr);
      check($sformatf("v%0d_ba", i),    d0_ba,   vecs[i].exp_ba);
      check($sformatf("v%0d_mask", i),  d0_mask, vecs[i].exp_mask);
      check($sformatf("v%0d_data", i),  d0_data, {vecs[i].data, vecs[i].data});
      check($sformatf("v%0d_smask", i), d1_mask, vecs[i].exp_mask_swab);
      ack();
      check($sformatf("v%0d_idle", i),  d0_we,   0);
    end

    // ---- header removal ----
    do_reset();
    downloading = 1'b1;
    step();
    hdr_seen = 1'b0;
    for (int i = 0; i < 16; i++) begin
      send(25'(i), 8'(i));
      if (d2_we) hdr_seen = 1'b1;
    end
    check("hdr_ignored", hdr_seen, 0);
    send(25'd16, 8'h5A);
    check("hdr_we",   d2_we,   1);
    check("hdr_addr", d2_addr, 0);
    check("hdr_ba",   d2_ba,   0);
    check("hdr_mask", d2_mask, 2'b10);
    check("hdr_data", d2_data, 16'h5A5A);
    ack();
    send(25'd17, 8'h5B);
    check("hdr1_mask", d2_mask, 2'b01);
    check("hdr1_addr", d2_addr, 0);

    // ---- overflow: three back-to-back bytes, prog_rdy withheld ----
    do_reset();
    downloading = 1'b1;
    step();
    send(25'h100, 8'hD0);
    send(25'h101, 8'hD1);
    send(25'h102, 8'hD2);
    check("ovf_set", d0_ovf, 1);
    for (int i = 0; i < 10; i++) step();
    check("ovf_hold_we",   d0_we,   1);
    check("ovf_hold_data", d0_data, 16'hD0D0);
    check("ovf_hold_addr", d0_addr, 23'h80);
    ack();
    check("ovf_2nd_we",   d0_we,   1);
    check("ovf_2nd_data", d0_data, 16'hD1D1);
    check("ovf_2nd_mask", d0_mask, 2'b01);
    check("ovf_2nd_addr", d0_addr, 23'h80);
    ack();
    check("ovf_3rd_dropped", d0_we, 0);
    downloading = 1'b0;
    step();
    check("ovf_sticky", d0_ovf, 1);
    downloading = 1'b1;
    step();
    check("ovf_clear", d0_ovf, 0);

    // ---- simultaneous prog_rdy and new byte with SKID full ----
    send(25'h200, 8'hE0);
    send(25'h201, 8'hE1);
    ioctl_addr = 25'h202;
    ioctl_data = 8'hE2;
    ioctl_wr   = 1'b1;
    prog_rdy   = 1'b1;
    step();
    ioctl_wr   = 1'b0;
    prog_rdy   = 1'b0;
    check("sim_data", d0_data, 16'hE1E1);
    check("sim_ovf",  d0_ovf,  0);
    ack();
    check("sim_next_data", d0_data, 16'hE2E2);
    check("sim_next_addr", d0_addr, 23'h101);
    check("sim_next_mask", d0_mask, 2'b10);
    ack();
    check("sim_idle", d0_we, 0);

    // ---- downloading falls with OUT and SKID full ----
    send(25'h300, 8'hF0);
    send(25'h301, 8'hF1);
    downloading = 1'b0;
    step();
    check("drain_busy0", d0_busy, 1);
    step();
    check("drain_busy1", d0_busy, 1);
    ack();
    check("drain_data", d0_data, 16'hF1F1);
    check("drain_busy2", d0_busy, 1);
    ack();
    check("drain_we",    d0_we,   0);
    check("drain_busy3", d0_busy, 1);
    step();
    check("drain_done", d0_busy, 0);

    // ---- reset with prog_we high and SKID full ----
    downloading = 1'b1;
    step();
    send(25'h40, 8'h11);
    send(25'h41, 8'h22);
    send(25'h42, 8'h33);
    check("prerst_ovf", d0_ovf, 1);
    rst_n = 1'b0;
    step();
    rst_n       = 1'b1;
    downloading = 1'b0;
    check("mrst_we",   d0_we,   0);
    check("mrst_addr", d0_addr, 0);
    check("mrst_data", d0_data, 0);
    check("mrst_mask", d0_mask, 0);
    check("mrst_ba",   d0_ba,   0);
    check("mrst_busy", d0_busy, 0);
    check("mrst_ovf",  d0_ovf,  0);
    ack();
    check("mrst_rdy_we", d0_we, 0);
    step();
    check("mrst_rdy_we2", d0_we, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
